// File: rtl/sq_dist_accum_sqrt.sv
// Sequential Euclidean-distance engine: accumulates sum((a_i-b_i)^2) over a
// vector with a saturating 32-bit sum, then runs a 16-cycle bit-serial
// restoring square root and offers {sum_sq, dist, ovf} on a valid/ready port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACCUM | accepting element pairs, summing squared differences
// ST_SQRT  | one root bit per cycle, 16 cycles, input stalled
// ST_OUT   | result offered downstream, held until taken
module sq_dist_accum_sqrt #(
  parameter int ELEM_W  = 9,
  parameter int VEC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_a,
  input  logic [ELEM_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_sum_sq,
  output logic [15:0]       out_dist,
  output logic              out_ovf
);

  localparam int SQ_W  = 2 * ELEM_W + 2;
  // One bit wider than the widest addend so the carry out flags saturation.
  localparam int SUM_W = (SQ_W > 32) ? SQ_W + 1 : 33;
  localparam logic [7:0] LAST_ELEM = 8'(VEC_LEN - 1);
  localparam logic [7:0] LAST_STEP = 8'd15;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_SQRT,
    ST_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [31:0] out_sum_sq_q, out_sum_sq_d;
  logic [15:0] out_dist_q, out_dist_d;
  logic        out_ovf_q, out_ovf_d;

  logic signed [ELEM_W:0] diff;
  logic [ELEM_W:0]        diff_mag;
  logic [SQ_W-1:0]        sq;
  logic [SUM_W-1:0]       sum_full;
  logic                   sum_sat;
  logic [31:0]            sum_next;

  logic [19:0] rem_sh;
  logic [19:0] trial;
  logic        take;
  logic [17:0] rem_step;
  logic [15:0] root_step;

  // Squared difference of the current operands and the saturating running sum.
  // |d| never reaches 2^ELEM_W, so the magnitude fits in ELEM_W+1 bits.
  always_comb begin
    diff = $signed({in_a[ELEM_W-1], in_a}) - $signed({in_b[ELEM_W-1], in_b});
    if (diff[ELEM_W]) diff_mag = $unsigned(-diff);
    else              diff_mag = $unsigned(diff);
    sq       = SQ_W'(diff_mag) * SQ_W'(diff_mag);
    sum_full = SUM_W'(acc_q) + SUM_W'(sq);
    sum_sat  = |sum_full[SUM_W-1:32];
    sum_next = sum_sat ? 32'hFFFF_FFFF : sum_full[31:0];
  end

  // One restoring square-root step: bring down two radicand bits, try root*4+1.
  // The remainder stays <= 2*root, so it fits in 18 bits between steps.
  always_comb begin
    rem_sh    = {rem_q, rad_q[31:30]};
    trial     = {2'b00, root_q, 2'b01};
    take      = (rem_sh >= trial);
    rem_step  = take ? 18'(rem_sh - trial) : rem_sh[17:0];
    root_step = {root_q[14:0], take};
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    rad_d        = rad_q;
    rem_d        = rem_q;
    root_d       = root_q;
    out_sum_sq_d = out_sum_sq_q;
    out_dist_d   = out_dist_q;
    out_ovf_d    = out_ovf_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum_next;
          ovf_d = ovf_q | sum_sat;
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = 8'd0;
            rad_d   = sum_next;
            rem_d   = 18'd0;
            root_d  = 16'd0;
            state_d = ST_SQRT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_SQRT: begin
        rad_d  = {rad_q[29:0], 2'b00};
        rem_d  = rem_step;
        root_d = root_step;
        if (cnt_q == LAST_STEP) begin
          cnt_d        = 8'd0;
          out_sum_sq_d = acc_q;
          out_dist_d   = root_step;
          out_ovf_d    = ovf_q;
          state_d      = ST_OUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = 32'd0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial vector or root.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      cnt_q        <= 8'd0;
      acc_q        <= 32'd0;
      ovf_q        <= 1'b0;
      rad_q        <= 32'd0;
      rem_q        <= 18'd0;
      root_q       <= 16'd0;
      out_sum_sq_q <= 32'd0;
      out_dist_q   <= 16'd0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      rad_q        <= rad_d;
      rem_q        <= rem_d;
      root_q       <= root_d;
      out_sum_sq_q <= out_sum_sq_d;
      out_dist_q   <= out_dist_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign out_sum_sq = out_sum_sq_q;
  assign out_dist   = out_dist_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_sq_dist_accum_sqrt.sv
// Bench for sq_dist_accum_sqrt: directed vectors with literal expectations,
// plus a transaction-level model checked against the DUT every cycle.
module tb_sq_dist_accum_sqrt;

  localparam int VEC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [8:0]  in_a, in_b;
  logic [31:0] out_sum_sq;
  logic [15:0] out_dist;

  logic        v16, rdy16, ov16, ordy16, ovf16;
  logic [15:0] a16, b16;
  logic [31:0] sum16;
  logic [15:0] dist16;

  sq_dist_accum_sqrt #(.ELEM_W(9), .VEC_LEN(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_sq(out_sum_sq), .out_dist(out_dist), .out_ovf(out_ovf)
  );

  sq_dist_accum_sqrt #(.ELEM_W(16), .VEC_LEN(VEC)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(ordy16),
    .out_sum_sq(sum16), .out_dist(dist16), .out_ovf(ovf16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r;
    longint t;
    r = 0;
    for (int k = 15; k >= 0; k--) begin
      t = r | (longint'(1) << k);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // Transaction model: phase 0 collecting, 1 computing root, 2 result offered.
  int     m_phase = 0;
  int     m_cnt   = 0;
  int     m_wait  = 0;
  longint m_acc   = 0;
  bit     m_ovf   = 0;
  longint m_res_sum  = 0;
  longint m_res_dist = 0;
  bit     m_res_ovf  = 0;

  always @(posedge clk or negedge rst_n) begin
    longint d;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_wait = 0; m_acc = 0; m_ovf = 0;
      m_res_sum = 0; m_res_dist = 0; m_res_ovf = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          d = longint'($signed(in_a)) - longint'($signed(in_b));
          m_acc = m_acc + d * d;
          if (m_acc > 64'hFFFF_FFFF) begin
            m_acc = 64'hFFFF_FFFF;
            m_ovf = 1;
          end
          m_cnt++;
          if (m_cnt == VEC) begin
            m_cnt = 0; m_wait = 0; m_phase = 1;
          end
        end
        1: begin
          m_wait++;
          if (m_wait == 16) begin
            m_phase = 2;
            m_res_sum = m_acc;
            m_res_dist = isqrt(m_acc);
            m_res_ovf = m_ovf;
          end
        end
        default: if (out_ready) begin
          m_phase = 0; m_acc = 0; m_ovf = 0;
        end
      endcase
    end
  end

  // Compare the DUT against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",   in_ready,   longint'(m_phase == 0));
      chk("out_valid",  out_valid,  longint'(m_phase == 2));
      chk("out_sum_sq", out_sum_sq, m_res_sum);
      chk("out_dist",   out_dist,   m_res_dist);
      chk("out_ovf",    out_ovf,    longint'(m_res_ovf));
    end
  end

  int va[VEC], vb[VEC], vbub[VEC];

  task automatic send_elem(input int a, input int b, input int bub);
    int g;
    for (int i = 0; i < bub; i++) begin
      in_valid = 1'b0;
      in_a = 9'($urandom);
      in_b = 9'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_a = 9'(a);
    in_b = 9'(b);
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 16);
  endtask

  task automatic run_vec(input string nm, input int hold, input longint es,
                         input longint ed, input int eo);
    int lat;
    out_ready = (hold == 0);
    for (int i = 0; i < VEC; i++) send_elem(va[i], vb[i], vbub[i]);
    wait_result(nm, lat);
    chk({nm, "_sum"},  out_sum_sq, es);
    chk({nm, "_dist"}, out_dist,   ed);
    chk({nm, "_ovf"},  out_ovf,    eo);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = 9'd1; in_b = 9'd0;
      @(posedge clk); #1;
      chk({nm, "_hold_sum"},   out_sum_sq, es);
      chk({nm, "_hold_dist"},  out_dist,   ed);
      chk({nm, "_hold_ready"}, in_ready,   0);
      chk({nm, "_hold_valid"}, out_valid,  1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_taken"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,   1);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_sum",       out_sum_sq, 0);
    chk("rst_dist",      out_dist,   0);
    chk("rst_ovf",       out_ovf,    0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    va = '{3, 0, 0, 0};          vb = '{0, 4, 0, 0};          vbub = '{0, 0, 0, 0};
    run_vec("v_3_4", 0, 25, 5, 0);

    va = '{-7, 12, 100, -256};   vb = '{-7, 12, 100, -256};   vbub = '{0, 0, 0, 0};
    run_vec("v_equal", 0, 0, 0, 0);

    va = '{255, 255, 255, 255};  vb = '{-256, -256, -256, -256}; vbub = '{0, 0, 0, 0};
    run_vec("v_extreme", 0, 1044484, 1022, 0);

    va = '{1, 2, 3, 4};          vb = '{0, 0, 0, 0};          vbub = '{0, 1, 2, 3};
    run_vec("v_bubbles", 0, 30, 5, 0);

    va = '{3, 4, 0, 0};          vb = '{0, 0, 0, 0};          vbub = '{0, 0, 0, 0};
    run_vec("v_stall", 5, 25, 5, 0);

    va = '{1, 1, 1, 1};          vb = '{0, 0, 0, 0};          vbub = '{0, 0, 0, 0};
    run_vec("v_after_stall", 0, 4, 2, 0);

    // Reset in the 8th SQRT cycle discards the root in flight.
    va = '{5, 6, 7, 8};          vb = '{0, 0, 0, 0};
    for (int i = 0; i < VEC; i++) send_elem(va[i], vb[i], 0);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_valid", out_valid,  0);
    chk("midreset_ready", in_ready,   1);
    chk("midreset_sum",   out_sum_sq, 0);
    chk("midreset_dist",  out_dist,   0);
    chk("midreset_ovf",   out_ovf,    0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    va = '{2, 0, 0, 0};          vb = '{0, 0, 0, 0};          vbub = '{0, 0, 0, 0};
    run_vec("v_after_reset", 0, 4, 2, 0);

    // Wide build: every difference is 65535, so the sum saturates.
    for (int i = 0; i < VEC; i++) begin
      chk("w16_ready", rdy16, 1);
      v16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h8000;
      @(posedge clk); #1;
    end
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", lat, 16);
    chk("w16_sum",  sum16,  64'hFFFF_FFFF);
    chk("w16_dist", dist16, 16'hFFFF);
    chk("w16_ovf",  ovf16,  1);
    @(posedge clk); #1;
    chk("w16_taken", ov16, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
